// File: rtl/gate_monitor_3lanpc_pkg.sv
// Shared definitions for the 3L-ANPC gate path: gate patterns, level codes,
// fault codes, state encodings and the combinational pattern classifier.
package gate_monitor_3lanpc_pkg;

  localparam logic [5:0] PAT_P   = 6'b110001;
  localparam logic [5:0] PAT_N   = 6'b001110;
  localparam logic [5:0] PAT_OP  = 6'b010010;
  localparam logic [5:0] PAT_OM  = 6'b001001;
  localparam logic [5:0] PAT_OFF = 6'b000000;

  localparam logic [1:0] LEV_N   = 2'd0;
  localparam logic [1:0] LEV_O   = 2'd1;
  localparam logic [1:0] LEV_P   = 2'd2;
  localparam logic [1:0] LEV_OFF = 2'd3;

  typedef enum logic [2:0] {
    FLT_NONE     = 3'd0,
    FLT_ILLEGAL  = 3'd1,
    FLT_DT_SHORT = 3'd2,
    FLT_TIMEOUT  = 3'd3
  } flt_e;

  typedef enum logic [1:0] {
    ST_OFF   = 2'd0,
    ST_LEVEL = 2'd1,
    ST_DEAD  = 2'd2,
    ST_FAULT = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    PC_OFF, PC_VALID, PC_PARTIAL, PC_ILLEGAL
  } pclass_e;

  typedef struct packed {
    pclass_e    cls;
    logic [1:0] lev;
  } pinfo_t;

  function automatic logic is_subset(input logic [5:0] p, input logic [5:0] v);
    return (p & ~v) == 6'b0;
  endfunction

  function automatic pinfo_t classify(input logic [5:0] p);
    pinfo_t r;
    r.cls = PC_ILLEGAL;
    r.lev = LEV_OFF;
    if (p == PAT_OFF) begin
      r.cls = PC_OFF;
    end else if (p == PAT_P) begin
      r.cls = PC_VALID;
      r.lev = LEV_P;
    end else if (p == PAT_N) begin
      r.cls = PC_VALID;
      r.lev = LEV_N;
    end else if (p == PAT_OP || p == PAT_OM) begin
      r.cls = PC_VALID;
      r.lev = LEV_O;
    end else if (is_subset(p, PAT_P) || is_subset(p, PAT_N) ||
                 is_subset(p, PAT_OP) || is_subset(p, PAT_OM)) begin
      r.cls = PC_PARTIAL;
    end
    return r;
  endfunction

endpackage

// File: rtl/gate_monitor_3lanpc_gate_sync.sv
// Multi-bit flip-flop synchronizer, STAGES deep; runs on every clock.
module gate_monitor_3lanpc_gate_sync #(
  parameter int W      = 6,
  parameter int STAGES = 2
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] stage_q [STAGES];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < STAGES; i++) stage_q[i] <= '0;
    end else begin
      stage_q[0] <= d_i;
      for (int i = 1; i < STAGES; i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign q_o = stage_q[STAGES-1];

endmodule

// File: rtl/gate_monitor_3lanpc.sv
// Reverse path of the 3L-ANPC gate decoder: reconstructs the output level from
// the applied gate signals, measures dead-times and latches gate faults.
module gate_monitor_3lanpc
  import gate_monitor_3lanpc_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 10,
  parameter int TRANS_W     = 16
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               ce_i,
  input  logic               s_1_i,
  input  logic               s_2_i,
  input  logic               s_3_i,
  input  logic               s_4_i,
  input  logic               s_5_i,
  input  logic               s_6_i,
  input  logic [CNT_W-1:0]   t_dead_min_i,
  input  logic [CNT_W-1:0]   t_timeout_i,
  input  logic               fault_clr_i,
  output logic [1:0]         v_lev_out_o,
  output logic               v_lev_valid_o,
  output logic [CNT_W-1:0]   dt_meas_o,
  output logic [TRANS_W-1:0] trans_cnt_o,
  output logic               fault_o,
  output logic [2:0]         fault_code_o
);

  logic [5:0]         pat_s;
  pinfo_t             pinfo;
  state_e             state_q;
  logic [5:0]         lvl_pat_q;
  logic [1:0]         v_lev_q;
  logic               valid_q;
  logic               fault_q;
  flt_e               code_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [CNT_W-1:0]   cnt_d;
  logic [CNT_W-1:0]   dt_q;
  logic [TRANS_W-1:0] trans_q;
  flt_e               flt_d;
  logic               timeout_hit;
  logic               is_valid;

  gate_monitor_3lanpc_gate_sync #(
    .W      (6),
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .d_i    ({s_1_i, s_2_i, s_3_i, s_4_i, s_5_i, s_6_i}),
    .q_o    (pat_s)
  );

  assign pinfo       = classify(pat_s);
  assign is_valid    = (pinfo.cls == PC_VALID);
  assign cnt_d       = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
  // The cycle that would bring the counter to t_timeout is the deciding one.
  assign timeout_hit = (t_timeout_i != '0) && (cnt_d >= t_timeout_i);

  // Fault raised this cycle; ordering of the checks gives ILLEGAL > DT_SHORT > TIMEOUT.
  always_comb begin
    flt_d = FLT_NONE;
    if (state_q != ST_FAULT) begin
      if (pinfo.cls == PC_ILLEGAL) begin
        flt_d = FLT_ILLEGAL;
      end else if (state_q == ST_LEVEL) begin
        if (is_valid && pat_s != lvl_pat_q && t_dead_min_i != '0) flt_d = FLT_DT_SHORT;
      end else if (state_q == ST_DEAD) begin
        if (is_valid && cnt_q < t_dead_min_i)                flt_d = FLT_DT_SHORT;
        else if (pinfo.cls == PC_PARTIAL && timeout_hit)      flt_d = FLT_TIMEOUT;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= ST_OFF;
      lvl_pat_q <= PAT_OFF;
      v_lev_q   <= LEV_OFF;
      valid_q   <= 1'b0;
      fault_q   <= 1'b0;
      code_q    <= FLT_NONE;
      cnt_q     <= '0;
      dt_q      <= '0;
      trans_q   <= '0;
    end else if (ce_i) begin
      if (flt_d != FLT_NONE) begin
        state_q <= ST_FAULT;
        code_q  <= flt_d;
        v_lev_q <= LEV_OFF;
        valid_q <= 1'b0;
        fault_q <= 1'b1;
      end else begin
        case (state_q)
          ST_OFF: begin
            if (is_valid) begin
              state_q   <= ST_LEVEL;
              lvl_pat_q <= pat_s;
              v_lev_q   <= pinfo.lev;
              valid_q   <= 1'b1;
            end
          end
          ST_LEVEL: begin
            if (is_valid && pat_s != lvl_pat_q) begin
              dt_q      <= '0;
              trans_q   <= trans_q + 1'b1;
              lvl_pat_q <= pat_s;
              v_lev_q   <= pinfo.lev;
            end else if (!is_valid) begin
              state_q <= ST_DEAD;
              cnt_q   <= CNT_W'(1);
              valid_q <= 1'b0;
            end
          end
          ST_DEAD: begin
            if (is_valid) begin
              dt_q      <= cnt_q;
              trans_q   <= trans_q + 1'b1;
              state_q   <= ST_LEVEL;
              lvl_pat_q <= pat_s;
              v_lev_q   <= pinfo.lev;
              valid_q   <= 1'b1;
            end else if (timeout_hit) begin
              state_q <= ST_OFF;
              v_lev_q <= LEV_OFF;
            end else begin
              cnt_q <= cnt_d;
            end
          end
          ST_FAULT: begin
            if (fault_clr_i && (pinfo.cls == PC_OFF || is_valid)) begin
              state_q <= ST_OFF;
              fault_q <= 1'b0;
              code_q  <= FLT_NONE;
            end
          end
          default: state_q <= ST_OFF;
        endcase
      end
    end
  end

  assign v_lev_out_o   = v_lev_q;
  assign v_lev_valid_o = valid_q;
  assign dt_meas_o     = dt_q;
  assign trans_cnt_o   = trans_q;
  assign fault_o       = fault_q;
  assign fault_code_o  = code_q;

endmodule

// File: tb/tb_gate_monitor_3lanpc.sv
// Directed bench for gate_monitor_3lanpc: level reconstruction, dead-time
// measurement, fault latching/clearing and asynchronous reset.
module tb_gate_monitor_3lanpc;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ce;
  logic [5:0]  pat;
  logic [9:0]  t_dead_min;
  logic [9:0]  t_timeout;
  logic        fault_clr;
  logic [1:0]  v_lev_out;
  logic        v_lev_valid;
  logic [9:0]  dt_meas;
  logic [15:0] trans_cnt;
  logic        fault;
  logic [2:0]  fault_code;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  gate_monitor_3lanpc #(
    .SYNC_STAGES (2),
    .CNT_W       (10),
    .TRANS_W     (16)
  ) dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .ce_i          (ce),
    .s_1_i         (pat[5]),
    .s_2_i         (pat[4]),
    .s_3_i         (pat[3]),
    .s_4_i         (pat[2]),
    .s_5_i         (pat[1]),
    .s_6_i         (pat[0]),
    .t_dead_min_i  (t_dead_min),
    .t_timeout_i   (t_timeout),
    .fault_clr_i   (fault_clr),
    .v_lev_out_o   (v_lev_out),
    .v_lev_valid_o (v_lev_valid),
    .dt_meas_o     (dt_meas),
    .trans_cnt_o   (trans_cnt),
    .fault_o       (fault),
    .fault_code_o  (fault_code)
  );

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [1:0] lev, input logic vld,
                         input logic flt, input logic [2:0] code);
    chk({tag, ".lev"},   32'(v_lev_out),   32'(lev));
    chk({tag, ".valid"}, 32'(v_lev_valid), 32'(vld));
    chk({tag, ".fault"}, 32'(fault),       32'(flt));
    chk({tag, ".code"},  32'(fault_code),  32'(code));
    $display("step %s: lev=%0d valid=%0d fault=%0d code=%0d dt=%0d trans=%0d",
             tag, v_lev_out, v_lev_valid, fault, fault_code, dt_meas, trans_cnt);
  endtask

  task automatic chk_cnt(input string tag, input int dt, input int tr);
    chk({tag, ".dt_meas"},   32'(dt_meas),   32'(dt));
    chk({tag, ".trans_cnt"}, 32'(trans_cnt), 32'(tr));
  endtask

  task automatic clear_fault();
    pat = 6'b000000;
    step(3);
    fault_clr = 1'b1;
    step(1);
    fault_clr = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; ce = 1'b1; pat = 6'b000000;
    t_dead_min = 10'd5; t_timeout = 10'd100; fault_clr = 1'b0;
    step(2);
    chk_out("reset", 2'd3, 1'b0, 1'b0, 3'd0);
    chk_cnt("reset", 0, 0);
    rst_n = 1'b1;

    // 1: enter P level, latency of three clocks
    pat = 6'b110001;
    step(2);
    chk_out("t1_latency_edge", 2'd3, 1'b0, 1'b0, 3'd0);
    step(1);
    chk_out("t1_level_p", 2'd2, 1'b1, 1'b0, 3'd0);

    // 2: legal dead-time of 7 cycles P -> O+
    pat = 6'b010001;
    step(7);
    chk_out("t2_in_dead", 2'd2, 1'b0, 1'b0, 3'd0);
    pat = 6'b010010;
    step(3);
    chk_out("t2_level_o", 2'd1, 1'b1, 1'b0, 3'd0);
    chk_cnt("t2", 7, 1);

    // 3: O+ -> P via 6-cycle dead, then a 3-cycle dead gives DT_SHORT
    pat = 6'b010000;
    step(6);
    pat = 6'b110001;
    step(3);
    chk_out("t3_level_p", 2'd2, 1'b1, 1'b0, 3'd0);
    chk_cnt("t3_legal", 6, 2);
    pat = 6'b010001;
    step(3);
    pat = 6'b010010;
    step(3);
    chk_out("t3_dt_short", 2'd3, 1'b0, 1'b1, 3'd2);
    chk_cnt("t3_frozen", 6, 2);
    pat = 6'b100010;
    step(4);
    chk_out("t3_first_code_kept", 2'd3, 1'b0, 1'b1, 3'd2);
    clear_fault();
    chk_out("t3_cleared", 2'd3, 1'b0, 1'b0, 3'd0);

    // 4: illegal pattern from LEVEL, fault_clr held has no effect
    pat = 6'b110001;
    step(3);
    chk_out("t4_level_p", 2'd2, 1'b1, 1'b0, 3'd0);
    pat = 6'b100010;
    fault_clr = 1'b1;
    step(2);
    chk_out("t4_before_illegal", 2'd2, 1'b1, 1'b0, 3'd0);
    step(1);
    chk_out("t4_illegal", 2'd3, 1'b0, 1'b1, 3'd1);
    step(3);
    chk_out("t4_clr_ignored", 2'd3, 1'b0, 1'b1, 3'd1);
    fault_clr = 1'b0;
    clear_fault();
    chk_out("t4_cleared", 2'd3, 1'b0, 1'b0, 3'd0);

    // 5: off pattern times out to OFF; partial pattern times out to TIMEOUT
    pat = 6'b110001;
    step(3);
    pat = 6'b000000;
    step(101);
    chk_out("t5_dead_99", 2'd2, 1'b0, 1'b0, 3'd0);
    step(1);
    chk_out("t5_off", 2'd3, 1'b0, 1'b0, 3'd0);
    chk_cnt("t5", 6, 2);
    pat = 6'b110001;
    step(3);
    pat = 6'b010000;
    step(101);
    chk_out("t5_partial_99", 2'd2, 1'b0, 1'b0, 3'd0);
    step(1);
    chk_out("t5_timeout", 2'd3, 1'b0, 1'b1, 3'd3);
    clear_fault();
    chk_out("t5_cleared", 2'd3, 1'b0, 1'b0, 3'd0);

    // 6: ce low for 10 cycles inside DEAD is excluded from dt_meas
    pat = 6'b110001;
    step(3);
    pat = 6'b010001;
    step(4);
    ce = 1'b0;
    step(10);
    ce = 1'b1;
    step(4);
    pat = 6'b010010;
    step(3);
    chk_out("t6_level_o", 2'd1, 1'b1, 1'b0, 3'd0);
    chk_cnt("t6_ce_gap", 8, 3);

    // 6b: asynchronous reset mid-DEAD with ce toggling
    pat = 6'b010000;
    step(3);
    for (int i = 0; i < 3; i++) begin
      ce = 1'b0;
      step(1);
      ce = 1'b1;
      step(1);
    end
    #2 rst_n = 1'b0;
    #1;
    chk_out("t6_async_reset", 2'd3, 1'b0, 1'b0, 3'd0);
    chk_cnt("t6_async_reset", 0, 0);
    pat = 6'b000000;
    step(2);
    rst_n = 1'b1;

    // 7: t_dead_min=0 allows direct valid-to-valid; re-enabling it faults
    t_dead_min = 10'd0;
    pat = 6'b110001;
    step(3);
    pat = 6'b010001;
    step(6);
    pat = 6'b001110;
    step(3);
    chk_out("t7_level_n", 2'd0, 1'b1, 1'b0, 3'd0);
    chk_cnt("t7_dead6", 6, 1);
    pat = 6'b001001;
    step(3);
    chk_out("t7_direct_om", 2'd1, 1'b1, 1'b0, 3'd0);
    chk_cnt("t7_direct", 0, 2);
    t_dead_min = 10'd5;
    pat = 6'b001110;
    step(3);
    chk_out("t7_direct_short", 2'd3, 1'b0, 1'b1, 3'd2);
    chk_cnt("t7_frozen", 0, 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
